// File: rtl/pad_stream_scheduler.sv
// Streams a zero-padded feature map one word per beat from a single-port SRAM.
// Optional macro PAD_SCHED_PERF_EN adds a saturating output-stall counter (stall_cnt).
module pad_stream_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 32,
    parameter int WIDTH      = 13,
    parameter int HEIGHT     = 17,
    parameter int PAD        = 1,
    parameter int ADDR_WIDTH = 13,
    parameter int FIFO_DEPTH = 4,
    localparam int PAD_W     = WIDTH + 2 * PAD,
    localparam int PAD_H     = HEIGHT + 2 * PAD,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int ROW_W     = $clog2(PAD_H),
    localparam int COL_W     = $clog2(PAD_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic [ROW_W-1:0]      out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  out_last
`ifdef PAD_SCHED_PERF_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PAD_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PAD_W - 1);
    localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(PAD);
    localparam logic [ROW_W-1:0] ROW_HI   = ROW_W'(PAD + HEIGHT);
    localparam logic [COL_W-1:0] COL_LO   = COL_W'(PAD);
    localparam logic [COL_W-1:0] COL_HI   = COL_W'(PAD + WIDTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
    state_t state, state_nxt;

    logic [CH_W-1:0]       ch;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic                  tag_valid, tag_last, tag_pad;
    logic [CH_W-1:0]       tag_ch;
    logic [ROW_W-1:0]      tag_row;
    logic [COL_W-1:0]      tag_col;

    logic [DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
    logic [CH_W-1:0]       f_ch   [FIFO_DEPTH];
    logic [ROW_W-1:0]      f_row  [FIFO_DEPTH];
    logic [COL_W-1:0]      f_col  [FIFO_DEPTH];
    logic                  f_last [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic                  start_ok, interior, pos_last, issue, push, pop, fifo_empty;
    logic [CW:0]           occupancy, limit;

    always_comb begin
        fifo_empty = (fifo_count == '0);
        pop        = !fifo_empty && out_ready;
        push       = tag_valid;
        start_ok   = (state == IDLE) && start && !abort;
        interior   = (row >= ROW_LO) && (row < ROW_HI) && (col >= COL_LO) && (col < COL_HI);
        pos_last   = (ch == CH_LAST) && (row == ROW_LAST) && (col == COL_LAST);
        occupancy  = (CW+1)'(fifo_count) + (CW+1)'(tag_valid);
        limit      = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
        issue      = (state == ISSUE) && !abort && (occupancy < limit);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (issue && pos_last) state_nxt = DRAIN;
            // Leave as soon as the final beat is popped so done follows acceptance by one cycle.
            DRAIN:   if (!tag_valid && (fifo_empty || (fifo_count == CW'(1) && pop)))
                         state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        busy      = (state == ISSUE) || (state == DRAIN);
        done      = (state == FINISH);
        mem_rd_en = issue && interior;
        mem_addr  = rd_addr;
        out_valid = !fifo_empty;
        out_data  = f_data[rd_ptr];
        out_ch    = f_ch[rd_ptr];
        out_row   = f_row[rd_ptr];
        out_col   = f_col[rd_ptr];
        out_last  = f_last[rd_ptr] && !fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Interior addresses are consecutive in scan order, so a running count replaces the
    // channel-base + row-offset sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch <= '0; row <= '0; col <= '0; rd_addr <= '0;
        end else if (abort || start_ok) begin
            ch <= '0; row <= '0; col <= '0; rd_addr <= '0;
        end else if (issue) begin
            if (interior) rd_addr <= rd_addr + ADDR_WIDTH'(1);
            if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row <= '0;
                    ch  <= (ch == CH_LAST) ? '0 : ch + CH_W'(1);
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= 1'b0; tag_last <= 1'b0; tag_pad <= 1'b0;
            tag_ch <= '0; tag_row <= '0; tag_col <= '0;
        end else if (abort) begin
            tag_valid <= 1'b0;
        end else begin
            tag_valid <= issue;
            if (issue) begin
                tag_ch   <= ch;
                tag_row  <= row;
                tag_col  <= col;
                tag_last <= pos_last;
                tag_pad  <= !interior;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0; rd_ptr <= '0; fifo_count <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                f_data[i] <= '0; f_ch[i] <= '0; f_row[i] <= '0; f_col[i] <= '0; f_last[i] <= 1'b0;
            end
        end else if (abort) begin
            wr_ptr <= '0; rd_ptr <= '0; fifo_count <= '0;
        end else begin
            if (push) begin
                f_data[wr_ptr] <= tag_pad ? '0 : mem_rd_data;
                f_ch[wr_ptr]   <= tag_ch;
                f_row[wr_ptr]  <= tag_row;
                f_col[wr_ptr]  <= tag_col;
                f_last[wr_ptr] <= tag_last;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef PAD_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                           stall_cnt <= '0;
        else if (start_ok)                                    stall_cnt <= '0;
        else if (busy && out_valid && !out_ready && stall_cnt != '1)
                                                              stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pad_stream_scheduler.sv
// Bench for pad_stream_scheduler: a small-geometry and a default-geometry instance checked
// every cycle against a beat-index model of the padded scan.
module tb_pad_stream_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start_s, abort_s, ready_s, rd_s, valid_s, last_s, busy_s, done_s;
    logic [12:0] addr_s;
    logic [31:0] rdata_s, data_s;
    logic [0:0]  ch_s;
    logic [1:0]  row_s;
    logic [2:0]  col_s;

    logic        start_d, abort_d, ready_d, rd_d, valid_d, last_d, busy_d, done_d;
    logic [12:0] addr_d;
    logic [31:0] rdata_d, data_d;
    logic [4:0]  ch_d;
    logic [4:0]  row_d;
    logic [3:0]  col_d;
`ifdef PAD_SCHED_PERF_EN
    logic [31:0] stall_s, stall_d;
`endif

    pad_stream_scheduler #(.NUM_CH(2), .WIDTH(3), .HEIGHT(2)) dut_s (
`ifdef PAD_SCHED_PERF_EN
        .stall_cnt(stall_s),
`endif
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .busy(busy_s), .done(done_s),
        .mem_rd_en(rd_s), .mem_addr(addr_s), .mem_rd_data(rdata_s), .out_valid(valid_s),
        .out_ready(ready_s), .out_data(data_s), .out_ch(ch_s), .out_row(row_s), .out_col(col_s),
        .out_last(last_s));

    pad_stream_scheduler dut_d (
`ifdef PAD_SCHED_PERF_EN
        .stall_cnt(stall_d),
`endif
        .clk(clk), .rst_n(rst_n), .start(start_d), .abort(abort_d), .busy(busy_d), .done(done_d),
        .mem_rd_en(rd_d), .mem_addr(addr_d), .mem_rd_data(rdata_d), .out_valid(valid_d),
        .out_ready(ready_d), .out_data(data_d), .out_ch(ch_d), .out_row(row_d), .out_col(col_d),
        .out_last(last_d));

    // SRAM models: word = address + 1, garbage when not read so pad masking is visible.
    always @(posedge clk) begin
        rdata_s <= rd_s ? {19'd0, addr_s} + 32'd1 : 32'hDEAD_BEEF;
        rdata_d <= rd_d ? {19'd0, addr_d} + 32'd1 : 32'hDEAD_BEEF;
    end

    int NCH [2] = '{2, 32};
    int W   [2] = '{3, 13};
    int H   [2] = '{2, 17};

    int          n_cmp = 0, n_err = 0, cyc = 0;
    int          exp_k [2], beats [2], rd_cnt [2], int_acc [2], csf [2], first_acc [2], last_acc [2];
    bit          busy_exp [2], last_prev [2], hold_prev [2], abort_prev [2], held_l [2];
    logic [31:0] held_d [2];
    int          held_t [2];
    logic [31:0] cap [40];

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_eq(input string name, input longint act, input longint exp);
        check(name, act == exp, act, exp);
    endtask

    task automatic model_reset(input int i);
        exp_k[i] = 0; beats[i] = 0; rd_cnt[i] = 0; int_acc[i] = 0; csf[i] = 0;
        first_acc[i] = 0; last_acc[i] = 0; busy_exp[i] = 0; last_prev[i] = 0;
        hold_prev[i] = 0; abort_prev[i] = 0; held_l[i] = 0; held_d[i] = 0; held_t[i] = 0;
    endtask

    task automatic mon(input int i, input logic v, input logic r, input logic [31:0] d,
                       input int c, input int ro, input int co, input logic l, input logic b,
                       input logic dn, input logic st, input logic ab, input logic rd);
        int pw, ph, tot, ec, er, ecol, tag;
        longint ed;
        bit inter, idle;
        pw = W[i] + 2; ph = H[i] + 2; tot = NCH[i] * ph * pw;
        tag = c * 1000000 + ro * 1000 + co;
        idle = !busy_exp[i] && !last_prev[i];
        check_eq("done", dn, last_prev[i]);
        check_eq("busy", b, busy_exp[i]);
        if (abort_prev[i]) check_eq("valid_after_abort", v, 0);
        else if (hold_prev[i]) begin
            check_eq("hold_valid", v, 1);
            check_eq("hold_data", d, held_d[i]);
            check_eq("hold_tag", tag, held_t[i]);
            check_eq("hold_last", l, held_l[i]);
        end
        if (csf[i] == 1 || csf[i] == 2) check_eq("early_valid", v, 0);
        if (csf[i] == 3) check_eq("first_valid", v, 1);
        if (v && r) begin
            if (exp_k[i] >= tot) check("extra_beat", 0, exp_k[i], tot - 1);
            else begin
                ec    = exp_k[i] / (ph * pw);
                er    = (exp_k[i] / pw) % ph;
                ecol  = exp_k[i] % pw;
                inter = er >= 1 && er <= H[i] && ecol >= 1 && ecol <= W[i];
                ed    = inter ? ec * H[i] * W[i] + (er - 1) * W[i] + (ecol - 1) + 1 : 0;
                check_eq("data", d, ed);
                check_eq("tag", tag, ec * 1000000 + er * 1000 + ecol);
                check_eq("last", l, exp_k[i] == tot - 1);
                if (inter) int_acc[i]++;
                if (i == 0) cap[exp_k[i]] = d;
            end
            if (beats[i] == 0) first_acc[i] = cyc;
            last_acc[i] = cyc;
            exp_k[i]++;
            beats[i]++;
        end
        if (rd) rd_cnt[i]++;
        if (busy_exp[i]) check("credit", rd_cnt[i] - int_acc[i] <= 4, rd_cnt[i] - int_acc[i], 4);
        last_prev[i]  = v && r && l;
        hold_prev[i]  = v && !r;
        held_d[i]     = d;
        held_t[i]     = tag;
        held_l[i]     = l;
        abort_prev[i] = ab;
        if (csf[i] != 0 && csf[i] < 3) csf[i]++;
        else csf[i] = 0;
        if (st && !ab && idle) begin
            busy_exp[i] = 1; exp_k[i] = 0; beats[i] = 0; rd_cnt[i] = 0; int_acc[i] = 0; csf[i] = 1;
        end else if (ab) begin
            busy_exp[i] = 0; csf[i] = 0; rd_cnt[i] = 0; int_acc[i] = 0;
        end else if (v && r && l) begin
            busy_exp[i] = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon(0, valid_s, ready_s, data_s, int'(ch_s), int'(row_s), int'(col_s), last_s, busy_s,
            done_s, start_s, abort_s, rd_s);
        mon(1, valid_d, ready_d, data_d, int'(ch_d), int'(row_d), int'(col_d), last_d, busy_d,
            done_d, start_d, abort_d, rd_d);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready held high, mode 1: ready toggles every cycle
    task automatic run_to_done(input int i, input int mode, input int lim, input string name);
        bit seen;
        seen = 0;
        for (int n = 0; n < lim && !seen; n++) begin
            if (i == 0) ready_s = (mode == 0) ? 1'b1 : cyc[0];
            else        ready_d = (mode == 0) ? 1'b1 : cyc[0];
            step();
            seen = (i == 0) ? done_s : done_d;
        end
        check_eq(name, seen, 1);
        ready_s = 1'b1;
        ready_d = 1'b1;
    endtask

    initial begin
        bit seen;
        start_s = 0; abort_s = 0; ready_s = 1; start_d = 0; abort_d = 0; ready_d = 1;
        rst_n = 0;
        model_reset(0); model_reset(1);
        repeat (3) step();
        check_eq("rst_ctrl_s", {busy_s, done_s, rd_s, valid_s, last_s}, 0);
        check_eq("rst_addr_s", addr_s, 0);
        check_eq("rst_data_s", data_s, 0);
        check_eq("rst_tag_s", {ch_s, row_s, col_s}, 0);
        check_eq("rst_ctrl_d", {busy_d, done_d, rd_d, valid_d, last_d}, 0);
        rst_n = 1;
        step();

        // Basic small frame, ready high
        start_s = 1; step(); start_s = 0;
        run_to_done(0, 0, 200, "basic_done");
        check_eq("basic_beats", beats[0], 40);
        check_eq("basic_span", last_acc[0] - first_acc[0], 39);
        for (int k = 0; k < 5; k++) check_eq("basic_row0", cap[k], 0);
        check_eq("basic_c0r1c1", cap[6], 1);
        check_eq("basic_c0r1c2", cap[7], 2);
        check_eq("basic_c1r2c3", cap[33], 12);
        check_eq("basic_final", cap[39], 0);
        repeat (3) step();

        // Backpressure on default geometry, with a start pulse while busy
        start_d = 1; step(); start_d = 0;
        seen = 0;
        for (int n = 0; n < 30000 && !seen; n++) begin
            ready_d = cyc[0];
            start_d = (n == 60);
            step();
            seen = done_d;
        end
        start_d = 0; ready_d = 1;
        check_eq("bp_done", seen, 1);
        check_eq("bp_beats", beats[1], 9120);
        repeat (3) step();

        // Full stall for 20 cycles after start
        ready_d = 0;
        start_d = 1; step(); start_d = 0;
        repeat (20) step();
        check_eq("stall_fill", dut_d.fifo_count, 4);
        check_eq("stall_inflight", dut_d.tag_valid, 0);
        check_eq("stall_valid", valid_d, 1);
        check_eq("stall_head_tag", {ch_d, row_d, col_d}, 0);
        check_eq("stall_head_data", data_d, 0);
        run_to_done(1, 0, 12000, "stall_done");
        check_eq("stall_beats", beats[1], 9120);
        repeat (3) step();

        // Abort after beat 100, then a fresh complete frame
        start_d = 1; step(); start_d = 0;
        for (int n = 0; n < 500 && beats[1] < 100; n++) step();
        check_eq("abort_reach100", beats[1], 100);
        abort_d = 1; step(); abort_d = 0;
        step();
        check_eq("abort_busy", busy_d, 0);
        check_eq("abort_valid", valid_d, 0);
        repeat (10) step();
        start_d = 1; step(); start_d = 0;
        run_to_done(1, 0, 12000, "reframe_done");
        check_eq("reframe_beats", beats[1], 9120);
        repeat (3) step();

        // start+abort together while idle, then mid-frame
        start_s = 1; abort_s = 1; step(); start_s = 0; abort_s = 0;
        repeat (3) step();
        check_eq("sa_idle_busy", busy_s, 0);
        check_eq("sa_idle_valid", valid_s, 0);
        start_s = 1; step(); start_s = 0;
        repeat (10) step();
        start_s = 1; abort_s = 1; step(); start_s = 0; abort_s = 0;
        step();
        check_eq("sa_mid_busy", busy_s, 0);
        check_eq("sa_mid_valid", valid_s, 0);
        repeat (5) step();

        // Reset mid-frame
        start_s = 1; step(); start_s = 0;
        repeat (10) step();
        rst_n = 0;
        model_reset(0); model_reset(1);
        #1;
        check_eq("rstmid_ctrl", {busy_s, done_s, valid_s, last_s}, 0);
        check_eq("rstmid_tag", {ch_s, row_s, col_s}, 0);
        step();
        rst_n = 1;
        step();

`ifdef PAD_SCHED_PERF_EN
        start_s = 1; step(); start_s = 0;
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            ready_s = !(n >= 10 && n < 17);
            step();
            seen = done_s;
        end
        ready_s = 1;
        check_eq("perf_done", seen, 1);
        check_eq("perf_stall", stall_s, 7);
        repeat (2) step();
        check_eq("perf_hold", stall_s, 7);
        start_s = 1; step(); start_s = 0;
        check_eq("perf_clear", stall_s, 0);
        run_to_done(0, 0, 200, "perf_done2");
        repeat (2) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
